// File: rtl/mult_share_arbiter.sv
// Shares one signed Q(WIDTH/2) fixed-point multiplier among NUM_REQ requesters with round-robin
// selection, a single registered response slot, per-requester sticky overflow and an op counter.

module multiplier #(
    parameter int WIDTH = 16,
    parameter int FRAC  = WIDTH / 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_flag_o
);
    logic signed [2*WIDTH-1:0] a_x;
    logic signed [2*WIDTH-1:0] b_x;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] scaled;

    assign a_x    = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    assign b_x    = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign prod   = a_x * b_x;
    assign scaled = prod >>> FRAC;

    // Truncated result wraps; overflow when the scaled product is not a sign extension of it.
    assign result_o        = scaled[WIDTH-1:0];
    assign overflow_flag_o = (scaled[2*WIDTH-1:WIDTH-1] != '0) &&
                             (scaled[2*WIDTH-1:WIDTH-1] != '1);
endmodule

module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_result,
    output logic                     rsp_overflow,
    output logic [NUM_REQ-1:0]       ovf_sticky,
    input  logic [NUM_REQ-1:0]       ovf_clear,
    output logic [15:0]              op_count
);
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic               rsp_overflow_q, rsp_overflow_d;
    logic [NUM_REQ-1:0] ovf_sticky_q, ovf_sticky_d;
    logic [15:0]        op_count_q, op_count_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W:0]      cand;
    logic [NUM_REQ-1:0] grant_onehot;
    logic               can_accept;
    logic               accept;
    logic [WIDTH-1:0]   mul_a, mul_b, mul_res;
    logic               mul_ovf;

    // Rotating priority search starting at rr_ptr; cand wraps without a modulo operator.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
    assign can_accept   = !rsp_valid_q || rsp_ready;
    assign accept       = grant_found && can_accept && !rst;
    assign req_ready    = accept ? grant_onehot : '0;
    assign mul_a        = req_a[grant_idx*WIDTH +: WIDTH];
    assign mul_b        = req_b[grant_idx*WIDTH +: WIDTH];

    multiplier #(.WIDTH(WIDTH)) u_mul (
        .a_i             (mul_a),
        .b_i             (mul_b),
        .result_o        (mul_res),
        .overflow_flag_o (mul_ovf)
    );

    always_comb begin
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_result_d   = rsp_result_q;
        rsp_overflow_d = rsp_overflow_q;
        op_count_d     = op_count_q;
        rr_ptr_d       = rr_ptr_q;
        if (accept) begin
            rsp_valid_d    = 1'b1;
            rsp_id_d       = grant_idx;
            rsp_result_d   = mul_res;
            rsp_overflow_d = mul_ovf;
            op_count_d     = op_count_q + 16'd1;
            rr_ptr_d       = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        // Set has priority over a same-cycle clear.
        ovf_sticky_d = (ovf_sticky_q & ~ovf_clear) |
                       ((accept && mul_ovf) ? grant_onehot : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_result_q   <= '0;
            rsp_overflow_q <= 1'b0;
            ovf_sticky_q   <= '0;
            op_count_q     <= '0;
            rr_ptr_q       <= '0;
        end else begin
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_result_q   <= rsp_result_d;
            rsp_overflow_q <= rsp_overflow_d;
            ovf_sticky_q   <= ovf_sticky_d;
            op_count_q     <= op_count_d;
            rr_ptr_q       <= rr_ptr_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_overflow = rsp_overflow_q;
    assign ovf_sticky   = ovf_sticky_q;
    assign op_count     = op_count_q;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed plus randomized bench for mult_share_arbiter against a behavioural arbiter/multiplier model.

module tb_mult_share_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic          rsp_valid, rsp_ready;
    logic [1:0]    rsp_id;
    logic [W-1:0]  rsp_result;
    logic          rsp_overflow;
    logic [N-1:0]  ovf_sticky, ovf_clear;
    logic [15:0]   op_count;
    logic [W-1:0]  g_a, g_b, g_res;
    logic          g_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic          m_rv;
    int            m_id;
    logic [15:0]   m_res;
    logic          m_ovf;
    logic [3:0]    m_sticky;
    logic [15:0]   m_cnt;
    int            m_ptr;
    logic [3:0]    last_ready;

    always #5 clk = ~clk;

    mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
        .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear), .op_count(op_count)
    );

    multiplier #(.WIDTH(W)) u_golden (
        .a_i(g_a), .b_i(g_b), .result_o(g_res), .overflow_flag_o(g_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Signed Q8.8 product: exact product scaled down by 256 (floor), wraps to 16 bits.
    task automatic mul_ref(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] res, output logic ovf);
        longint p, q;
        p   = longint'($signed(a)) * longint'($signed(b));
        q   = p >>> 8;
        ovf = (q > 32767) || (q < -32768);
        res = q[15:0];
    endtask

    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_rv = 1'b0; m_id = 0; m_res = '0; m_ovf = 1'b0;
        m_sticky = '0; m_cnt = '0; m_ptr = 0;
    endtask

    // One clock: drive after a falling edge, check grant, step model at rising edge, check outputs.
    task automatic cycle(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                         input logic rr, input logic [3:0] clr, input logic r, input bit chk_on);
        int g;
        logic acc;
        logic [3:0] exp_ready, set_mask;
        logic [15:0] res;
        logic ovf;
        req_valid = v; req_a = a; req_b = b; rsp_ready = rr; ovf_clear = clr; rst = r;
        #1;
        g = pick(v, m_ptr);
        acc = !r && (!m_rv || rr) && (g >= 0);
        exp_ready = acc ? 4'(1 << g) : 4'b0000;
        if (chk_on) chk("req_ready", 32'(req_ready), 32'(exp_ready));
        last_ready = req_ready;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            set_mask = '0;
            if (acc) begin
                mul_ref(a[g*16 +: 16], b[g*16 +: 16], res, ovf);
                m_rv = 1'b1; m_id = g; m_res = res; m_ovf = ovf;
                m_ptr = (g + 1) % N;
                m_cnt = m_cnt + 16'd1;
                if (ovf) set_mask[g] = 1'b1;
            end else if (rr) begin
                m_rv = 1'b0;
            end
            m_sticky = (m_sticky & ~clr) | set_mask;
        end
        @(negedge clk);
        if (chk_on) begin
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            chk("rsp_id", 32'(rsp_id), 32'(m_id));
            chk("rsp_result", 32'(rsp_result), 32'(m_res));
            chk("rsp_overflow", 32'(rsp_overflow), 32'(m_ovf));
            chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
            chk("op_count", 32'(op_count), 32'(m_cnt));
        end
    endtask

    initial begin
        logic [63:0] ra, rb;
        logic [15:0] ea, eb, eres;
        logic [7:0]  s8a, s8b;
        logic        eovf;
        model_reset();
        last_ready = '0;
        g_a = '0; g_b = '0;

        // Reset from an unknown state
        cycle(4'h0, '0, '0, 1'b0, 4'h0, 1'b1, 1'b1);
        cycle(4'h0, '0, '0, 1'b0, 4'h0, 1'b1, 1'b1);

        // Single request on requester 2
        cycle(4'b0100, '0, 64'h1234_0000_0000, 1'b1, 4'h0, 1'b0, 1'b1);
        chk("single_grant", 32'(last_ready), 32'h4);
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_count", 32'(op_count), 32'd1);
        cycle(4'h0, '0, '0, 1'b1, 4'h0, 1'b0, 1'b1);
        chk("single_drain", 32'(rsp_valid), 32'd0);

        // Fairness from a fresh pointer
        cycle(4'h0, '0, '0, 1'b1, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            cycle(4'hF, ra, rb, 1'b1, 4'h0, 1'b0, 1'b1);
            chk("rr_order", 32'(last_ready), 32'(1 << (i % 4)));
            chk("rr_rsp_id", 32'(rsp_id), 32'(i % 4));
        end
        chk("rr_count", 32'(op_count), 32'd8);

        // Backpressure: one accept, then the slot stays full for 5 cycles
        ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
        cycle(4'hF, ra, rb, 1'b1, 4'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(4'hF, ra, rb, 1'b0, 4'h0, 1'b0, 1'b1);
            chk("bp_no_grant", 32'(last_ready), 32'h0);
            chk("bp_hold_id", 32'(rsp_id), 32'd0);
        end
        cycle(4'hF, ra, rb, 1'b1, 4'h0, 1'b0, 1'b1);
        chk("bp_refill_grant", 32'(last_ready), 32'h2);
        chk("bp_refill_id", 32'(rsp_id), 32'd1);
        chk("bp_count", 32'(op_count), 32'd10);

        // Reset mid-stream with requests pending and a full response slot
        cycle(4'hF, ra, rb, 1'b0, 4'h0, 1'b0, 1'b1);
        cycle(4'hF, ra, rb, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("rst_ready", 32'(last_ready), 32'h0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_count", 32'(op_count), 32'd0);
        cycle(4'b1010, ra, rb, 1'b1, 4'h0, 1'b0, 1'b1);
        chk("rst_first_grant", 32'(last_ready), 32'h2);

        // Random operands per requester, cross-checked against the standalone multiplier too
        for (int r = 0; r < N; r++) begin
            for (int n = 0; n < 100; n++) begin
                s8a = 8'($urandom); s8b = 8'($urandom);
                ea = (n % 2 == 1) ? {{8{s8a[7]}}, s8a} : 16'($urandom);
                eb = (n % 2 == 1) ? {{8{s8b[7]}}, s8b} : 16'($urandom);
                g_a = ea; g_b = eb;
                #1;
                mul_ref(ea, eb, eres, eovf);
                chk("golden_res", 32'(g_res), 32'(eres));
                chk("golden_ovf", 32'(g_ovf), 32'(eovf));
                ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
                ra[r*16 +: 16] = ea; rb[r*16 +: 16] = eb;
                cycle(4'(1 << r), ra, rb, 1'b1, 4'h0, 1'b0, 1'b1);
            end
        end

        // Random mix of requests, backpressure and clears
        for (int n = 0; n < 300; n++) begin
            ra = {$urandom, $urandom}; rb = {$urandom, $urandom};
            cycle(4'($urandom), ra, rb, 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0, 1'b0, 1'b1);
        end

        // Sticky overflow set, set-beats-clear, clear alone
        cycle(4'h0, '0, '0, 1'b1, 4'h0, 1'b1, 1'b1);
        ra = 64'h0000_0000_7FFF_0000; rb = 64'h0000_0000_7FFF_0000;
        cycle(4'b0010, ra, rb, 1'b1, 4'h0, 1'b0, 1'b1);
        chk("ovf_set", 32'(ovf_sticky), 32'h2);
        chk("ovf_rsp", 32'(rsp_overflow), 32'd1);
        cycle(4'b0010, ra, rb, 1'b1, 4'b0010, 1'b0, 1'b1);
        chk("ovf_set_wins", 32'(ovf_sticky), 32'h2);
        cycle(4'h0, '0, '0, 1'b1, 4'b0010, 1'b0, 1'b1);
        chk("ovf_clear", 32'(ovf_sticky), 32'h0);

        // Counter wrap
        cycle(4'h0, '0, '0, 1'b1, 4'h0, 1'b1, 1'b1);
        for (int n = 0; n < 65535; n++) begin
            cycle(4'hF, '0, '0, 1'b1, 4'h0, 1'b0, 1'b0);
        end
        chk("wrap_pre", 32'(op_count), 32'hFFFF);
        cycle(4'hF, 64'h0100_0100_0100_0100, 64'h0200_0200_0200_0200, 1'b1, 4'h0, 1'b0, 1'b1);
        chk("wrap_post", 32'(op_count), 32'h0);
        chk("wrap_grant", 32'(last_ready), 32'h8);
        chk("wrap_result", 32'(rsp_result), 32'h0200);
        cycle(4'hF, '0, '0, 1'b1, 4'h0, 1'b0, 1'b1);
        chk("wrap_next_grant", 32'(last_ready), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
